// File: rtl/ddr_burst_arbiter.sv
// DDR burst-port arbiter: serialises ISA refill, data refill and data write-back
// bursts onto the single DDR controller port. Fixed priority store > load > isa,
// with an aging counter that promotes a repeatedly losing ISA request.
module ddr_burst_arbiter #(
    parameter int unsigned DDR_ADDR_WIDTH   = 28,
    parameter int unsigned LEN_WIDTH        = 10,
    parameter int unsigned DATA_CACHE_DEPTH = 16,
    parameter int unsigned STARVE_LIMIT     = 4
) (
    input  logic                      mem_clk,
    input  logic                      rst,
    input  logic                      init_done,
    input  logic                      isa_req,
    input  logic [DDR_ADDR_WIDTH-1:0] isa_addr,
    input  logic [LEN_WIDTH-1:0]      isa_len,
    input  logic                      dload_req,
    input  logic [DDR_ADDR_WIDTH-1:0] dload_addr,
    input  logic                      dstore_req,
    input  logic [DDR_ADDR_WIDTH-1:0] dstore_addr,
    output logic                      isa_gnt,
    output logic                      dload_gnt,
    output logic                      dstore_gnt,
    output logic                      isa_done,
    output logic                      dload_done,
    output logic                      dstore_done,
    output logic                      rd_burst_req,
    output logic [LEN_WIDTH-1:0]      rd_burst_len,
    output logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr,
    input  logic                      rd_burst_finish,
    output logic                      wr_burst_req,
    output logic [LEN_WIDTH-1:0]      wr_burst_len,
    output logic [DDR_ADDR_WIDTH-1:0] wr_burst_addr,
    input  logic                      wr_burst_finish,
    output logic                      busy,
    output logic [2:0]                arb_state
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StRdBurst = 3'd1,
        StWrBurst = 3'd2,
        StDone    = 3'd3,
        StSkip    = 3'd4
    } state_e;

    // Data-cache bursts move one full line plus one beat.
    localparam logic [LEN_WIDTH-1:0] DataLen   = LEN_WIDTH'(DATA_CACHE_DEPTH + 1);
    localparam logic [2:0]           StarveMax = 3'(STARVE_LIMIT);

    state_e     state_q;
    logic [2:0] skip_cnt_q;
    logic       any_req;
    logic       isa_promoted;
    logic       win_isa;
    logic       win_load;
    logic       win_store;

    assign arb_state = state_q;

    // Winner selection from the requests sampled this cycle.
    always_comb begin
        any_req      = isa_req | dload_req | dstore_req;
        isa_promoted = isa_req && (skip_cnt_q == StarveMax);
        win_store    = !isa_promoted && dstore_req;
        win_load     = !isa_promoted && !dstore_req && dload_req;
        win_isa      = isa_promoted || (isa_req && !dstore_req && !dload_req);
    end

    // Arbitration FSM with registered grant, burst request and done outputs.
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            skip_cnt_q    <= 3'd0;
            isa_gnt       <= 1'b0;
            dload_gnt     <= 1'b0;
            dstore_gnt    <= 1'b0;
            isa_done      <= 1'b0;
            dload_done    <= 1'b0;
            dstore_done   <= 1'b0;
            rd_burst_req  <= 1'b0;
            rd_burst_len  <= '0;
            rd_burst_addr <= '0;
            wr_burst_req  <= 1'b0;
            wr_burst_len  <= '0;
            wr_burst_addr <= '0;
            busy          <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (init_done && any_req) begin
                        busy <= 1'b1;
                        // Aging: count grants the waiting ISA request lost.
                        if (win_isa || !isa_req) begin
                            skip_cnt_q <= 3'd0;
                        end else if (skip_cnt_q != StarveMax) begin
                            skip_cnt_q <= skip_cnt_q + 3'd1;
                        end
                        if (win_store) begin
                            dstore_gnt    <= 1'b1;
                            wr_burst_req  <= 1'b1;
                            wr_burst_addr <= dstore_addr;
                            wr_burst_len  <= DataLen;
                            state_q       <= StWrBurst;
                        end else if (win_load) begin
                            dload_gnt     <= 1'b1;
                            rd_burst_req  <= 1'b1;
                            rd_burst_addr <= dload_addr;
                            rd_burst_len  <= DataLen;
                            state_q       <= StRdBurst;
                        end else if (isa_len != '0) begin
                            isa_gnt       <= 1'b1;
                            rd_burst_req  <= 1'b1;
                            rd_burst_addr <= isa_addr;
                            rd_burst_len  <= isa_len;
                            state_q       <= StRdBurst;
                        end else begin
                            // Zero-length fetch: acknowledge without touching DDR.
                            state_q <= StSkip;
                        end
                    end
                end
                StRdBurst: begin
                    if (rd_burst_finish) begin
                        rd_burst_req <= 1'b0;
                        isa_gnt      <= 1'b0;
                        dload_gnt    <= 1'b0;
                        isa_done     <= isa_gnt;
                        dload_done   <= dload_gnt;
                        state_q      <= StDone;
                    end
                end
                StWrBurst: begin
                    if (wr_burst_finish) begin
                        wr_burst_req <= 1'b0;
                        dstore_gnt   <= 1'b0;
                        dstore_done  <= 1'b1;
                        state_q      <= StDone;
                    end
                end
                StSkip: begin
                    isa_done <= 1'b1;
                    state_q  <= StDone;
                end
                StDone: begin
                    isa_done    <= 1'b0;
                    dload_done  <= 1'b0;
                    dstore_done <= 1'b0;
                    busy        <= 1'b0;
                    state_q     <= StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
